// File: rtl/button_event_if.sv
// button_event_if
//   Bundle between a debounced button source and the event decoder.
//   master : drives stabilized_button, observes the decoded events
//   slave  : samples stabilized_button, drives the decoded events
//   Signals:
//     stabilized_button  debounced level, 1 = pressed
//     press_pulse        one-cycle pulse on press
//     release_pulse      one-cycle pulse on release
//     long_pulse         one-cycle pulse when the hold reaches the long threshold
//     repeat_pulse       one-cycle pulse per repeat interval after long_pulse
//     held               high while the button is considered held
//     repeat_count       repeat pulses in the current hold, saturating
interface button_event_if #(
  parameter int RPT_W = 8
) ();
  logic             stabilized_button;
  logic             press_pulse;
  logic             release_pulse;
  logic             long_pulse;
  logic             repeat_pulse;
  logic             held;
  logic [RPT_W-1:0] repeat_count;

  modport master (
    output stabilized_button,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse,
    input  repeat_pulse,
    input  held,
    input  repeat_count
  );

  modport slave (
    input  stabilized_button,
    output press_pulse,
    output release_pulse,
    output long_pulse,
    output repeat_pulse,
    output held,
    output repeat_count
  );
endinterface

// File: rtl/button_event_decoder.sv
// button_event_decoder
//   Turns the debounced button level into single-cycle press, release,
//   long-press and auto-repeat events for downstream counter/control logic.
//   All outputs are registered; events appear one clk after the sampling edge.
//   Ports:
//     clk    system clock, all logic on posedge
//     reset  synchronous, active-high
//     bus    button_event_if.slave (button level in, events out)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | button released, waiting for a rising level
//   PRESSED | button held, counting toward the long-press threshold
//   REPEAT  | long-press reached, emitting a repeat pulse every interval
module button_event_decoder #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int CNT_W         = 26,
  parameter int RPT_W         = 8
) (
  input  logic           clk,
  input  logic           reset,
  button_event_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  state_t           state;
  logic             btn_q;
  logic [CNT_W-1:0] cnt;
  logic             press_q;
  logic             release_q;
  logic             long_q;
  logic             repeat_q;
  logic             held_q;
  logic [RPT_W-1:0] repeat_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      btn_q          <= 1'b0;
      cnt            <= '0;
      press_q        <= 1'b0;
      release_q      <= 1'b0;
      long_q         <= 1'b0;
      repeat_q       <= 1'b0;
      held_q         <= 1'b0;
      repeat_count_q <= '0;
    end else begin
      btn_q     <= bus.stabilized_button;
      // Event outputs are pulses: cleared every cycle unless re-asserted below.
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;

      unique case (state)
        IDLE: begin
          // btn_q low guarantees a genuine rising level, so a button still
          // high after reset yields a fresh press.
          if (bus.stabilized_button && !btn_q) begin
            press_q        <= 1'b1;
            held_q         <= 1'b1;
            cnt            <= '0;
            repeat_count_q <= '0;
            state          <= PRESSED;
          end
        end

        PRESSED: begin
          // Release is tested first so it wins over a coincident long-press.
          if (!bus.stabilized_button) begin
            release_q <= 1'b1;
            held_q    <= 1'b0;
            state     <= IDLE;
          end else if (cnt == LONG_LAST) begin
            long_q <= 1'b1;
            cnt    <= '0;
            state  <= REPEAT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        REPEAT: begin
          if (!bus.stabilized_button) begin
            release_q <= 1'b1;
            held_q    <= 1'b0;
            state     <= IDLE;
          end else if (cnt == REPEAT_LAST) begin
            repeat_q <= 1'b1;
            cnt      <= '0;
            if (repeat_count_q != '1) begin
              repeat_count_q <= repeat_count_q + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.long_pulse    = long_q;
  assign bus.repeat_pulse  = repeat_q;
  assign bus.held          = held_q;
  assign bus.repeat_count  = repeat_count_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder
//   Directed bench: dut_a uses LONG=8/REPEAT=4, dut_b uses LONG=8/REPEAT=2
//   for the repeat_count saturation case. Both share clk and reset.
module tb_button_event_decoder;

  logic clk = 1'b0;
  logic reset;
  logic mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  button_event_if #(.RPT_W(8)) bif_a ();
  button_event_if #(.RPT_W(8)) bif_b ();

  button_event_decoder #(
    .LONG_CYCLES  (8),
    .REPEAT_CYCLES(4),
    .CNT_W        (26),
    .RPT_W        (8)
  ) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bif_a)
  );

  button_event_decoder #(
    .LONG_CYCLES  (8),
    .REPEAT_CYCLES(2),
    .CNT_W        (26),
    .RPT_W        (8)
  ) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bif_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic p, input logic r, input logic l,
                         input logic rp, input logic h, input int rc);
    check({tag, "_press"},   32'(bif_a.press_pulse),   32'(p));
    check({tag, "_release"}, 32'(bif_a.release_pulse), 32'(r));
    check({tag, "_long"},    32'(bif_a.long_pulse),    32'(l));
    check({tag, "_repeat"},  32'(bif_a.repeat_pulse),  32'(rp));
    check({tag, "_held"},    32'(bif_a.held),          32'(h));
    check({tag, "_rcount"},  32'(bif_a.repeat_count),  32'(rc));
  endtask

  // Button high for h sampled edges starting at t0; expectations derived
  // from LONG=8, REPEAT=4: long at t0+8, repeats at t0+12,16,..., release at t0+h.
  task automatic hold_test(input string tag, input int h);
    int   nrep;
    logic e_long;
    logic e_rpt;
    nrep = 0;
    bif_a.stabilized_button = 1'b1;
    for (int i = 0; i <= h; i++) begin
      step();
      e_long = (h > 8) && (i == 8);
      e_rpt  = (i > 8) && (i < h) && (((i - 8) % 4) == 0);
      if (e_rpt) nrep++;
      check_a($sformatf("%s_c%0d", tag, i), i == 0, i == h, e_long, e_rpt, i < h, nrep);
      if (i == h - 1) bif_a.stabilized_button = 1'b0;
    end
    step();
    check_a({tag, "_after"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, nrep);
    step();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      assert ($onehot0({bif_a.press_pulse, bif_a.release_pulse, bif_a.long_pulse, bif_a.repeat_pulse}))
      else begin
        errors++;
        $error("FAIL onehot_a: observed=%b expected=at most one",
               {bif_a.press_pulse, bif_a.release_pulse, bif_a.long_pulse, bif_a.repeat_pulse});
      end
      checks++;
      assert ($onehot0({bif_b.press_pulse, bif_b.release_pulse, bif_b.long_pulse, bif_b.repeat_pulse}))
      else begin
        errors++;
        $error("FAIL onehot_b: observed=%b expected=at most one",
               {bif_b.press_pulse, bif_b.release_pulse, bif_b.long_pulse, bif_b.repeat_pulse});
      end
    end
  end

  initial begin
    int nrep_b;

    // 1. reset with toggling button: everything stays 0
    reset = 1'b1;
    bif_a.stabilized_button = 1'b1;
    bif_b.stabilized_button = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      mon_en = 1'b1;
      check_a($sformatf("rst_c%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      bif_a.stabilized_button = ~bif_a.stabilized_button;
    end
    bif_a.stabilized_button = 1'b0;
    reset = 1'b0;
    step();
    step();
    check_a("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // 2. short press
    hold_test("short", 5);

    // 3. long press with three repeats; count holds after release
    hold_test("long", 22);
    check("long_rc_hold", 32'(bif_a.repeat_count), 32'd3);

    // 4. release on the edge where long would fire
    hold_test("race", 8);

    // 5. reset mid-hold with the button still high
    bif_a.stabilized_button = 1'b1;
    for (int i = 0; i <= 13; i++) begin
      step();
      if (i == 0)  check_a("mid_c0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      if (i == 12) check_a("mid_c12", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
      if (i == 13) check_a("mid_c13", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    end
    reset = 1'b1;
    step();
    check_a("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    reset = 1'b0;
    step();
    check_a("mid_repress", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    step();
    check_a("mid_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    bif_a.stabilized_button = 1'b0;
    step();
    check_a("mid_release", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    step();

    // 6. repeat_count saturation on dut_b (REPEAT=2): repeat k at t0+8+2k
    nrep_b = 0;
    bif_b.stabilized_button = 1'b1;
    for (int i = 0; i <= 600; i++) begin
      step();
      if (bif_b.repeat_pulse === 1'b1) nrep_b++;
      if (i == 0)   check("sat_press", 32'(bif_b.press_pulse), 32'd1);
      if (i == 8)   check("sat_long", 32'(bif_b.long_pulse), 32'd1);
      if (i == 10)  check("sat_rpt1", 32'(bif_b.repeat_count), 32'd1);
      if (i == 516) check("sat_rc254", 32'(bif_b.repeat_count), 32'd254);
      if (i == 518) begin
        check("sat_rpt255", 32'(bif_b.repeat_pulse), 32'd1);
        check("sat_rc255", 32'(bif_b.repeat_count), 32'd255);
      end
      if (i == 520) begin
        check("sat_rpt256", 32'(bif_b.repeat_pulse), 32'd1);
        check("sat_rc_hold", 32'(bif_b.repeat_count), 32'd255);
      end
      if (i == 599) check("sat_rc_end", 32'(bif_b.repeat_count), 32'd255);
      if (i == 600) begin
        check("sat_release", 32'(bif_b.release_pulse), 32'd1);
        check("sat_held", 32'(bif_b.held), 32'd0);
      end
      if (i == 599) bif_b.stabilized_button = 1'b0;
    end
    check("sat_npulses", 32'(nrep_b), 32'd295);
    step();
    check("sat_rc_after", 32'(bif_b.repeat_count), 32'd255);
    check("a_quiet", 32'(bif_a.held), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
